// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: pipeline hazard inputs and the forwarding/stall/flush
// controls they produce.
//   master : pipeline side; drives the register/stage info, consumes the controls
//   slave  : hazard_ctrl side; consumes the stage info, drives the controls
//   rs1_D/rs2_D, rs1_use_D/rs2_use_D  decode-stage sources and their use flags
//   rs1_E/rs2_E                       execute-stage sources
//   rd_E/rd_M/rd_W, wr_E/wr_M/wr_W    destinations and write enables in E/M/W
//   load_E, br_taken_E, trap_M        load in E, taken branch in E, trap redirect in M
//   ext_busy                          multi-cycle wait, freezes the whole pipe
//   fwd_a_sel/fwd_b_sel               operand selects: 00 regfile, 01 M, 10 W
//   stall_F/D/E/M, flush_D/E/M        per-stage hold and zero controls
interface hazard_ctrl_if;
  logic [4:0] rs1_D;
  logic [4:0] rs2_D;
  logic       rs1_use_D;
  logic       rs2_use_D;
  logic [4:0] rs1_E;
  logic [4:0] rs2_E;
  logic [4:0] rd_E;
  logic [4:0] rd_M;
  logic [4:0] rd_W;
  logic       wr_E;
  logic       wr_M;
  logic       wr_W;
  logic       load_E;
  logic       br_taken_E;
  logic       trap_M;
  logic       ext_busy;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;
  logic       stall_F;
  logic       stall_D;
  logic       stall_E;
  logic       stall_M;
  logic       flush_D;
  logic       flush_E;
  logic       flush_M;

  modport master (
    output rs1_D, rs2_D, rs1_use_D, rs2_use_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
           wr_E, wr_M, wr_W, load_E, br_taken_E, trap_M, ext_busy,
    input  fwd_a_sel, fwd_b_sel, stall_F, stall_D, stall_E, stall_M,
           flush_D, flush_E, flush_M
  );

  modport slave (
    input  rs1_D, rs2_D, rs1_use_D, rs2_use_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
           wr_E, wr_M, wr_W, load_E, br_taken_E, trap_M, ext_busy,
    output fwd_a_sel, fwd_b_sel, stall_F, stall_D, stall_E, stall_M,
           flush_D, flush_E, flush_M
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32 core.
// Computes execute-stage forwarding selects and sequences load-use bubbles, freezes,
// branch redirects and trap flushes through one FSM; counts stall cycles and redirects.
//   clk        clock, all state on posedge
//   rst        asynchronous active-low reset; forces every control output to 0
//   hz         hazard_ctrl_if.slave bundle (stage info in, fwd/stall/flush out)
//   stall_cnt  cycles with stall_F=1, wraps
//   flush_cnt  accepted branch/trap redirects, wraps
module hazard_ctrl #(
  parameter int unsigned LOAD_BUBBLES = 1,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  hazard_ctrl_if.slave     hz,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {StRun, StLuStall, StFreeze, StRedirect} state_e;

  localparam logic [1:0]       BubLast = 2'(LOAD_BUBBLES - 1);
  localparam logic [1:0]       RcInit  = 2'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  state_e     state_q, state_d;
  logic [1:0] bub_q, bub_d;   // bubbles already issued for the current load-use
  logic [1:0] rc_q, rc_d;     // remaining flush_D cycles in REDIRECT
  logic       lu_hit, redirect_ev;
  logic       s_f, s_d, s_e, s_m, f_d, f_e, f_m;
  logic [1:0] fwd_a, fwd_b;

  // M beats W; x0 is never forwarded.
  always_comb begin
    fwd_a = 2'b00;
    if (hz.wr_M && hz.rd_M != 5'd0 && hz.rs1_E == hz.rd_M) begin
      fwd_a = 2'b01;
    end else if (hz.wr_W && hz.rd_W != 5'd0 && hz.rs1_E == hz.rd_W) begin
      fwd_a = 2'b10;
    end
    fwd_b = 2'b00;
    if (hz.wr_M && hz.rd_M != 5'd0 && hz.rs2_E == hz.rd_M) begin
      fwd_b = 2'b01;
    end else if (hz.wr_W && hz.rd_W != 5'd0 && hz.rs2_E == hz.rd_W) begin
      fwd_b = 2'b10;
    end
  end

  assign lu_hit = hz.load_E & hz.wr_E & (hz.rd_E != 5'd0) &
                  ((hz.rs1_use_D & (hz.rs1_D == hz.rd_E)) |
                   (hz.rs2_use_D & (hz.rs2_D == hz.rd_E)));

  always_comb begin
    state_d     = state_q;
    bub_d       = bub_q;
    rc_d        = rc_q;
    redirect_ev = 1'b0;
    {s_f, s_d, s_e, s_m, f_d, f_e, f_m} = '0;

    // A trap wins in every state.
    if (hz.trap_M) begin
      {f_d, f_e, f_m} = 3'b111;
      redirect_ev     = 1'b1;
    end else begin
      unique case (state_q)
        // FREEZE with ext_busy low releases by evaluating the cycle like RUN, so a
        // hazard present at release is not lost.
        StRun, StFreeze: begin
          if (hz.ext_busy) begin
            {s_f, s_d, s_e, s_m} = 4'b1111;
            state_d = StFreeze;
          end else if (hz.br_taken_E) begin
            {f_d, f_e}  = 2'b11;
            redirect_ev = 1'b1;
          end else if (lu_hit) begin
            {s_f, s_d, f_e} = 3'b111;
            if (LOAD_BUBBLES > 1) begin
              state_d = StLuStall;
              bub_d   = 2'd1;
            end else begin
              state_d = StRun;
            end
          end else begin
            state_d = StRun;
          end
        end
        StLuStall: begin
          if (hz.ext_busy) begin
            // Remaining bubbles are re-derived from lu_hit after the freeze.
            {s_f, s_d, s_e, s_m} = 4'b1111;
            state_d = StFreeze;
          end else if (hz.br_taken_E) begin
            {f_d, f_e}  = 2'b11;
            redirect_ev = 1'b1;
          end else begin
            {s_f, s_d, f_e} = 3'b111;
            if (bub_q >= BubLast) begin
              state_d = StRun;
            end else begin
              bub_d = bub_q + 2'd1;
            end
          end
        end
        StRedirect: begin
          if (hz.br_taken_E) begin
            {f_d, f_e}  = 2'b11;
            redirect_ev = 1'b1;
          end else begin
            f_d = 1'b1;
            if (rc_q <= 2'd1) begin
              state_d = StRun;
            end else begin
              rc_d = rc_q - 2'd1;
            end
          end
        end
        default: state_d = StRun;
      endcase
    end

    if (redirect_ev) begin
      rc_d    = RcInit;
      state_d = (RcInit != 2'd0) ? StRedirect : StRun;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StRun;
      bub_q     <= 2'd0;
      rc_q      <= 2'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state_q <= state_d;
      bub_q   <= bub_d;
      rc_q    <= rc_d;
      if (s_f) begin
        stall_cnt <= stall_cnt + CntOne;
      end
      if (redirect_ev) begin
        flush_cnt <= flush_cnt + CntOne;
      end
    end
  end

  // Controls are held at 0 for as long as reset is asserted.
  assign hz.fwd_a_sel = rst ? fwd_a : 2'b00;
  assign hz.fwd_b_sel = rst ? fwd_b : 2'b00;
  assign hz.stall_F   = rst & s_f;
  assign hz.stall_D   = rst & s_d;
  assign hz.stall_E   = rst & s_e;
  assign hz.stall_M   = rst & s_m;
  assign hz.flush_D   = rst & f_d;
  assign hz.flush_E   = rst & f_e;
  assign hz.flush_M   = rst & f_m;

endmodule
